// File: rtl/regfile_sb.sv
// Multi-read-port GPR file with a per-register in-flight scoreboard; r0 reads zero and is never busy.
// Optional write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ack,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy;

  logic wr_en;
  logic iss_set;
  logic cnt_inc;
  logic cnt_dec;

  assign wr_en = we && (waddr != '0);

  // A busy destination may still be re-issued when its producer retires this very cycle.
  assign iss_ack = iss_valid &&
                   ((iss_addr == '0) || !busy[iss_addr] || (we && (waddr == iss_addr)));
  assign iss_set = iss_ack && (iss_addr != '0);

  // Counter moves only on real 0->1 / 1->0 transitions of the busy vector.
  assign cnt_inc = iss_set && !busy[iss_addr];
  assign cnt_dec = wr_en && busy[waddr] && !(iss_set && (iss_addr == waddr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[waddr]  <= wdata;
        busy[waddr] <= 1'b0;
      end
      // Issue comes last so a same-cycle re-issue keeps the register busy.
      if (iss_set) begin
        busy[iss_addr] <= 1'b1;
      end
      case ({cnt_inc, cnt_dec})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = raddr[gi*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      logic fwd;
      assign fwd = rst && wr_en && (waddr == ra);
      assign rdata[gi*DATA_W +: DATA_W] = fwd ? wdata : mem[ra];
      assign rbusy[gi] = fwd ? (iss_set && (iss_addr == ra)) : busy[ra];
`else
      assign rdata[gi*DATA_W +: DATA_W] = mem[ra];
      assign rbusy[gi] = busy[ra];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus randomized bench for regfile_sb against an array-based architectural model.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NREGS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0] rbusy;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic          iss_ack;
  logic [AW:0]   pend_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ack(iss_ack),
    .pend_cnt(pend_cnt)
  );

  logic [31:0] mem_m [NREGS];
  bit          busy_m [NREGS];
  int vectors = 0;
  int miscompares = 0;

  // Observations captured during the most recent step, for directed spot checks.
  logic        last_ack;
  logic [AW:0] last_pend;
  logic [31:0] last_rd0, last_rd1;
  logic        last_rb0, last_rb1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pend_m();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += busy_m[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mem_m[i] = '0;
      busy_m[i] = 1'b0;
    end
  endtask

  task automatic step(input bit w, input int wa, input logic [31:0] wd,
                      input int r0, input int r1, input bit iv, input int ia);
    bit ack;
    logic [31:0] ed [2];
    bit eb [2];
    int ra [2];
    logic [4:0] wa5, ia5, r05, r15;
    @(negedge clk);
    wa5 = wa[4:0]; ia5 = ia[4:0]; r05 = r0[4:0]; r15 = r1[4:0];
    we = w; waddr = wa5; wdata = wd;
    raddr = {r15, r05};
    iss_valid = iv; iss_addr = ia5;
    ack = iv && (ia == 0 || !busy_m[ia] || (w && wa == ia));
    ra[0] = r0; ra[1] = r1;
    for (int k = 0; k < 2; k++) begin
      ed[k] = mem_m[ra[k]];
      eb[k] = busy_m[ra[k]];
`ifdef REGFILE_BYPASS_EN
      if (w && wa != 0 && wa == ra[k]) begin
        ed[k] = wd;
        eb[k] = ack && (ia == ra[k]);
      end
`endif
    end
    #1;
    last_ack = iss_ack; last_pend = pend_cnt;
    last_rd0 = rdata[31:0]; last_rd1 = rdata[63:32];
    last_rb0 = rbusy[0]; last_rb1 = rbusy[1];
    chk("iss_ack", iss_ack, ack);
    chk("pend_cnt", pend_cnt, pend_m());
    chk($sformatf("rdata0[r%0d]", r0), rdata[31:0], ed[0]);
    chk($sformatf("rdata1[r%0d]", r1), rdata[63:32], ed[1]);
    chk($sformatf("rbusy0[r%0d]", r0), rbusy[0], eb[0]);
    chk($sformatf("rbusy1[r%0d]", r1), rbusy[1], eb[1]);
    $display("t=%0t we=%0b wa=%0d wd=%h ra=%0d/%0d iss=%0b/%0d ack=%0b pend=%0d",
             $time, w, wa, wd, r0, r1, iv, ia, iss_ack, pend_cnt);
    @(posedge clk);
    if (w && wa != 0) begin
      mem_m[wa] = wd;
      busy_m[wa] = 1'b0;
    end
    if (ack && ia != 0) busy_m[ia] = 1'b1;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without waiting for clk.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd7;
    raddr = {5'd3, 5'd5};
    #1;
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_rbusy", rbusy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_iss_ack", iss_ack, 1);
    $display("t=%0t reset asserted pend=%0d", $time, pend_cnt);
    model_clear();
    @(negedge clk);
    iss_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    iss_valid = 1'b1;
    #1;
    chk("init_pend_cnt", pend_cnt, 0);
    chk("init_rdata", rdata, 0);
    chk("init_rbusy", rbusy, 0);
    chk("init_iss_ack", iss_ack, 1);
    iss_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic write then read on both ports.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 5, 5, 0, 0);
    chk("r5_port0", last_rd0, 32'hDEADBEEF);
    chk("r5_port1", last_rd1, 32'hDEADBEEF);
    chk("r5_rbusy", {last_rb1, last_rb0}, 0);

    // r0 ignores writes and accepts issues without becoming busy.
    step(1, 0, 32'h1234, 0, 0, 1, 0);
    chk("r0_iss_ack", last_ack, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("r0_read", last_rd0, 0);
    chk("r0_pend", last_pend, 0);

    // WAW stall on r7, then retire.
    step(0, 0, 0, 7, 7, 1, 7);
    chk("r7_first_ack", last_ack, 1);
    step(0, 0, 0, 7, 7, 1, 7);
    chk("r7_second_ack", last_ack, 0);
    chk("r7_pend_busy", last_pend, 1);
    step(1, 7, 32'h55, 7, 7, 0, 0);
    step(0, 0, 0, 7, 7, 0, 0);
    chk("r7_pend_clear", last_pend, 0);
    chk("r7_data", last_rd0, 32'h55);

    // Same-cycle retire and re-issue on r9 keeps it busy.
    step(0, 0, 0, 9, 9, 1, 9);
    step(1, 9, 32'hA5, 9, 9, 1, 9);
    chk("r9_reissue_ack", last_ack, 1);
    step(0, 0, 0, 9, 9, 0, 0);
    chk("r9_data", last_rd0, 32'hA5);
    chk("r9_rbusy", last_rb0, 1);
    chk("r9_pend", last_pend, 1);

    // Write-read in the same cycle: forwarded only with bypass.
    step(1, 3, 32'hCAFE, 3, 3, 0, 0);
`ifdef REGFILE_BYPASS_EN
    chk("r3_same_cycle", last_rd0, 32'hCAFE);
`else
    chk("r3_same_cycle", last_rd0, 0);
`endif
    chk("r3_same_rbusy", last_rb0, 0);
    step(0, 0, 0, 3, 3, 0, 0);
    chk("r3_next_cycle", last_rd1, 32'hCAFE);

    // Fill the scoreboard, then reset in the middle of activity.
    step(1, 9, 32'h0, 0, 0, 0, 0);
    for (int i = 1; i < NREGS; i++) step(0, 0, 0, i, 0, 1, i);
    step(0, 0, 0, 31, 1, 0, 0);
    chk("full_pend", last_pend, 31);
    do_reset();
    step(0, 0, 0, 5, 3, 0, 0);
    chk("post_rst_r5", last_rd0, 0);

    // Randomized traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 300; n++) begin
      int mx;
      mx = ($urandom_range(0, 3) == 0) ? 31 : 7;
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, mx)), $urandom,
           int'($urandom_range(0, mx)), int'($urandom_range(0, mx)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, mx)));
      if (n == 150) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
